// File: rtl/rs_codeword_serializer.sv
// Buffers RS(68,64) codewords from the parallel encoder and streams them out as
// BEAT_BYTES-wide valid/ready beats. Codewords that arrive while the buffer is full are dropped.
module rs_codeword_serializer #(
  parameter int BEAT_BYTES = 4,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0][7:0]        msg_in,
  input  logic [3:0][7:0]         parity_in,
  input  logic                    vld_in,
  output logic [8*BEAT_BYTES-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    overflow,
  output logic                    busy
);

  localparam int CW_BYTES = 68;
  localparam int BEATS    = CW_BYTES / BEAT_BYTES;
  localparam int BEAT_W   = 8 * BEAT_BYTES;
  localparam int PW       = $clog2(DEPTH);
  localparam int BTW      = $clog2(BEATS);
  localparam int CNTW     = $clog2(DEPTH + 1);

  typedef logic [BEATS-1:0][BEAT_W-1:0] entry_t;
  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  entry_t            r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]   r_count;
  logic [BTW-1:0]    r_beat;
  logic              r_ovf;
  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_valid;
  logic              w_last_beat;
  logic              w_full;
  logic              w_fire;
  logic              w_pop;
  logic              w_push;
  entry_t            w_cw;
  entry_t            w_rd_entry;
  logic [BEAT_W-1:0] w_beat_data;

  // Packed so that message byte 0 lands in lane 0 of beat 0 and parity follows byte 63.
  assign w_cw = {parity_in, msg_in};

  assign w_full      = (r_count == CNTW'(DEPTH));
  assign w_last_beat = (r_beat == BTW'(BEATS - 1));
  assign w_fire      = w_valid & m_ready;
  assign w_pop       = w_fire & w_last_beat;
  // A full buffer still accepts when its head codeword retires on this same edge.
  assign w_push      = rst_n & vld_in & (~w_full | w_pop);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY:  if (w_push) w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop && !w_push && r_count == CNTW'(1)) w_state_nxt = S_EMPTY;
      default:  w_state_nxt = S_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    w_valid = 1'b0;
    case (r_state)
      S_STREAM: w_valid = 1'b1;
      default:  w_valid = 1'b0;
    endcase
  end

  assign m_valid = w_valid;
  assign m_last  = w_valid & w_last_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fire) begin
        if (w_last_beat) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          r_beat   <= '0;
        end else begin
          r_beat   <= r_beat + BTW'(1);
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= vld_in & ~w_push;
    end
  end

  // Codeword storage is plain RAM; its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cw;
  end

  assign w_rd_entry  = r_mem[r_rd_ptr];
  assign w_beat_data = w_rd_entry[r_beat];

  genvar l;
  generate
    for (l = 0; l < BEAT_BYTES; l++) begin : g_lane
      assign m_data[l*8 +: 8] = w_valid ? w_beat_data[l*8 +: 8] : 8'h00;
    end
  endgenerate

  assign overflow = r_ovf;
  assign busy     = (r_count != '0);

endmodule

// File: tb/tb_rs_codeword_serializer.sv
// Bench for rs_codeword_serializer: a queue-of-codewords reference model checked every cycle,
// plus directed sequences for latency, stalls, overflow, full-with-pop, mid-stream reset and 1-byte beats.
module tb_rs_codeword_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [63:0][7:0] msg;
  logic [3:0][7:0]  par;
  logic             vld, rdy;

  logic [31:0] a_data;
  logic        a_valid, a_last, a_ovf, a_busy;
  logic [7:0]  b_data;
  logic        b_valid, b_last, b_ovf, b_busy;

  rs_codeword_serializer #(.BEAT_BYTES(4), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .msg_in(msg), .parity_in(par), .vld_in(vld),
    .m_data(a_data), .m_valid(a_valid), .m_ready(rdy), .m_last(a_last),
    .overflow(a_ovf), .busy(a_busy));

  rs_codeword_serializer #(.BEAT_BYTES(1), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .msg_in(msg), .parity_in(par), .vld_in(vld),
    .m_data(b_data), .m_valid(b_valid), .m_ready(rdy), .m_last(b_last),
    .overflow(b_ovf), .busy(b_busy));

  typedef logic [543:0] cw_t;
  typedef struct {int idx; logic [31:0] data; logic last;} vec_t;

  cw_t q[$];
  int  mbeat, nbeats, bb, dp, sel, cyc;
  logic movf;
  int  checks = 0, errors = 0;
  logic [31:0] s_data;
  logic s_valid, s_last, s_ovf, s_busy;
  logic [31:0] log_d[$];
  bit  log_l[$];
  int  log_c[$];
  int  ovf_cnt;
  vec_t tv[4];

  function automatic cw_t cur_cw();
    cw_t c;
    for (int k = 0; k < 64; k++) c[k*8 +: 8] = msg[k];
    for (int p = 0; p < 4; p++)  c[(64+p)*8 +: 8] = par[p];
    return c;
  endfunction

  function automatic logic [31:0] beat_of(cw_t c, int b, int n);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < n; l++) r[l*8 +: 8] = c[(b*n+l)*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    log_d.delete(); log_l.delete(); log_c.delete(); ovf_cnt = 0;
  endtask

  // Reference: codewords are a FIFO of at most dp entries, the head is sent nbeats beats long.
  task automatic model_edge();
    bit mv, ml, pop, push;
    if (!rst_n) begin
      q.delete(); mbeat = 0; movf = 1'b0;
      return;
    end
    mv   = q.size() > 0;
    ml   = mv && (mbeat == nbeats - 1);
    pop  = mv && rdy && ml;
    push = vld && ((q.size() < dp) || pop);
    if (mv && rdy) begin
      log_d.push_back(s_data); log_l.push_back(s_last); log_c.push_back(cyc);
      if (ml) begin void'(q.pop_front()); mbeat = 0; end
      else mbeat++;
    end
    if (push) q.push_back(cur_cw());
    movf = vld && !push;
  endtask

  task automatic cycle();
    logic        ev, el;
    logic [31:0] ed;
    cw_t         h;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    s_data  = sel ? {24'h0, b_data} : a_data;
    s_valid = sel ? b_valid : a_valid;
    s_last  = sel ? b_last  : a_last;
    s_ovf   = sel ? b_ovf   : a_ovf;
    s_busy  = sel ? b_busy  : a_busy;
    ev = q.size() > 0;
    el = ev && (mbeat == nbeats - 1);
    ed = '0;
    if (ev) begin h = q[0]; ed = beat_of(h, mbeat, bb); end
    chk("m_valid", s_valid, ev);
    chk("m_last", s_last, el);
    chk("m_data", s_data, ed);
    chk("overflow", s_ovf, movf);
    chk("busy", s_busy, ev);
    if (s_ovf) ovf_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_sel(input int s);
    sel = s; bb = s ? 1 : 4; dp = s ? 4 : 2; nbeats = 68 / bb;
    do_reset();
  endtask

  task automatic set_cw(input int seed);
    for (int k = 0; k < 64; k++) msg[k] = 8'((k*7 + seed*31 + 3) & 255);
    for (int p = 0; p < 4; p++)  par[p] = 8'((p*13 + seed*57 + 11) & 255);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 64; k++) msg[k] = 8'(k);
    for (int p = 0; p < 4; p++)  par[p] = 8'(8'hA0 + p);
  endtask

  task automatic check_table(input string nm);
    chk({nm, "_nbeats"}, log_d.size(), 17);
    for (int i = 0; i < 4; i++) begin
      if (tv[i].idx < log_d.size()) begin
        chk({nm, "_beat"}, log_d[tv[i].idx], tv[i].data);
        chk({nm, "_last"}, log_l[tv[i].idx], tv[i].last);
      end else begin
        chk({nm, "_beat_missing"}, log_d.size(), tv[i].idx + 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cw_t c1, c2, c7;
    logic [31:0] pd;
    logic pl, pv, pr;
    int n;

    tv[0] = '{0,  32'h03020100, 1'b0};
    tv[1] = '{1,  32'h07060504, 1'b0};
    tv[2] = '{15, 32'h3F3E3D3C, 1'b0};
    tv[3] = '{16, 32'hA3A2A1A0, 1'b1};

    cyc = 0; rst_n = 1'b0; vld = 1'b0; rdy = 1'b0; msg = '0; par = '0;
    mbeat = 0; movf = 1'b0;
    set_sel(0);
    chk("rst_valid", s_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_data", s_data, 0);

    // 1: single codeword, free-flowing sink
    clear_log(); set_ramp(); rdy = 1'b1;
    vld = 1'b1; cycle(); vld = 1'b0;
    chk("t1_latency", s_valid, 1);
    for (int i = 0; i < 22; i++) cycle();
    check_table("t1");
    chk("t1_busy_after", s_busy, 0);

    // 2: alternating ready, outputs must hold during stalls
    clear_log(); rdy = 1'b1;
    vld = 1'b1; cycle(); vld = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy = (i % 2 == 0);
      pd = s_data; pl = s_last; pv = s_valid; pr = rdy;
      cycle();
      if (pv && !pr) begin
        chk("t2_stall_valid", s_valid, 1);
        chk("t2_stall_data", s_data, pd);
        chk("t2_stall_last", s_last, pl);
      end
    end
    check_table("t2");

    // 3: three codewords into a stalled 2-entry buffer
    clear_log(); rdy = 1'b0;
    set_cw(1); c1 = cur_cw(); vld = 1'b1; cycle(); chk("t3_ovf_t1", s_ovf, 0);
    set_cw(2); c2 = cur_cw();             cycle(); chk("t3_ovf_t2", s_ovf, 0);
    set_cw(3);                            cycle(); chk("t3_ovf_t3", s_ovf, 1);
    vld = 1'b0; cycle(); chk("t3_ovf_t4", s_ovf, 0);
    rdy = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    chk("t3_nbeats", log_d.size(), 34);
    if (log_d.size() == 34) begin
      chk("t3_cw1_b0", log_d[0], beat_of(c1, 0, 4));
      chk("t3_cw1_last", log_l[16], 1);
      chk("t3_cw2_b0", log_d[17], beat_of(c2, 0, 4));
      chk("t3_cw2_b16", log_d[33], beat_of(c2, 16, 4));
      chk("t3_cw2_last", log_l[33], 1);
    end
    chk("t3_ovf_pulses", ovf_cnt, 1);

    // 4: full buffer, new codeword arrives as the head's final beat is accepted
    clear_log(); rdy = 1'b1;
    set_cw(4); vld = 1'b1; cycle();
    set_cw(5);             cycle();
    vld = 1'b0;
    n = 0;
    while (!(s_valid && s_last) && n < 40) begin cycle(); n++; end
    chk("t4_wait_last", n < 40, 1);
    set_cw(6); vld = 1'b1; cycle(); vld = 1'b0;
    chk("t4_no_ovf", s_ovf, 0);
    chk("t4_busy", s_busy, 1);
    for (int i = 0; i < 50; i++) cycle();
    chk("t4_nbeats", log_d.size(), 51);
    if (log_d.size() == 51) chk("t4_contig", log_c[50] - log_c[0], 50);
    chk("t4_ovf_pulses", ovf_cnt, 0);

    // 5: reset at beat 7 with a second codeword queued
    do_reset(); clear_log(); rdy = 1'b1;
    set_cw(8); vld = 1'b1; cycle();
    set_cw(9);             cycle();
    vld = 1'b0;
    n = 0;
    while (log_d.size() < 7 && n < 30) begin cycle(); n++; end
    chk("t5_wait_beat7", log_d.size(), 7);
    set_cw(10); rst_n = 1'b0; vld = 1'b1; cycle();
    rst_n = 1'b1; vld = 1'b0;
    chk("t5_valid_rst", s_valid, 0);
    chk("t5_busy_rst", s_busy, 0);
    chk("t5_data_rst", s_data, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_still_idle", s_valid, 0);
    clear_log();
    set_cw(7); c7 = cur_cw(); vld = 1'b1; cycle(); vld = 1'b0;
    for (int i = 0; i < 22; i++) cycle();
    chk("t5_nbeats", log_d.size(), 17);
    if (log_d.size() > 0) chk("t5_new_b0", log_d[0], beat_of(c7, 0, 4));

    // 6: 1-byte beats, 4-deep, four back-to-back codewords
    set_sel(1); clear_log(); rdy = 1'b1;
    for (int s = 11; s < 15; s++) begin set_cw(s); vld = 1'b1; cycle(); end
    vld = 1'b0;
    for (int i = 0; i < 290; i++) cycle();
    chk("t6_nbeats", log_d.size(), 272);
    if (log_d.size() == 272) begin
      n = 0;
      for (int i = 0; i < 272; i++) if (log_l[i]) n++;
      chk("t6_nlast", n, 4);
      chk("t6_last67", log_l[67], 1);
      chk("t6_last135", log_l[135], 1);
      chk("t6_last203", log_l[203], 1);
      chk("t6_last271", log_l[271], 1);
      chk("t6_contig", log_c[271] - log_c[0], 271);
    end
    chk("t6_ovf_pulses", ovf_cnt, 0);

    // Random traffic on both configurations
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      for (int i = 0; i < 1500; i++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        vld   = ($urandom_range(0, 3) == 0);
        rdy   = ($urandom_range(0, 2) != 0);
        set_cw(int'($urandom_range(0, 1000)));
        cycle();
      end
      rst_n = 1'b1; vld = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
